program_loader: RTL
===================

Name: program_loader

Overview:
Boot-time loader sitting directly upstream of cpu. It accepts a word stream on a valid/ready interface and writes it into instruction memory, then into data memory, through the cpu external memory ports (addr_ext/wen_ext/ren_ext/wdata_ext/rdata_ext and the _2 set). It then reads instruction memory back and checks a checksum. On a match it raises cpu_enable, which drives cpu.enable.

Parameters:
DATA_W, 32, stream and memory word width
IMEM_WORDS, 512, instruction memory depth (cpu instruction_memory ADDR_W=9)
DMEM_WORDS, 1024, data memory depth (cpu data_memory ADDR_W=10)

Ports:
clk  in  1  main clock
arst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle load request, honoured only in IDLE
abort  in  1  return to IDLE from any state
imem_len  in  10  instruction words to load, 0..512
dmem_len  in  11  data words to load, 0..1024
s_valid  in  1  stream word valid
s_data  in  32  stream word
s_ready  out  1  loader accepts s_data this cycle
imem_addr  out  32  to cpu addr_ext, byte address
imem_wen  out  1  to cpu wen_ext
imem_ren  out  1  to cpu ren_ext
imem_wdata  out  32  to cpu wdata_ext
imem_rdata  in  32  from cpu rdata_ext
dmem_addr  out  32  to cpu addr_ext_2, byte address
dmem_wen  out  1  to cpu wen_ext_2
dmem_wdata  out  32  to cpu wdata_ext_2
cpu_enable  out  1  to cpu enable
busy  out  1  high in LOAD_I, LOAD_D or VERIFY
done  out  1  high in RUN
err  out  1  high in ERROR

Behaviour:
- Interface: one clock (clk). Reset is asynchronous and active-low (arst_n).
- Reset: state IDLE, counters and checksums cleared, all outputs 0.
- States: IDLE, LOAD_I, LOAD_D, VERIFY, RUN, ERROR. The state register and counters are flopped. Memory-side outputs are combinational from state, counter and s_valid.
- IDLE + start:
  - imem_len>512 or dmem_len>1024 -> ERROR next cycle; nothing is written.
  - Otherwise latch both lengths, clear wr_sum and rd_sum, clear counter, then go to the first non-empty state among LOAD_I, LOAD_D. If both lengths are 0, go to RUN.
- Word addressing: word i sits at byte address 4*i. Unused address bits are 0.
- LOAD_I:
  - s_ready=1.
  - Each cycle with s_valid=1: imem_wen=1, imem_addr=4*cnt, imem_wdata=s_data, wr_sum+=s_data (mod 2^32), cnt++.
  - When word imem_len-1 is accepted, clear cnt and go to LOAD_D, or to VERIFY if dmem_len=0.
  - s_valid=0 cycles are gaps: no write, no state change.
- LOAD_D: same as LOAD_I on the dmem_* ports, dmem_len words. Data words are not checksummed. On the last word go to VERIFY if imem_len>0, else RUN.
- VERIFY:
  - s_ready=0.
  - Cycles 0..imem_len-1: imem_ren=1, imem_addr=4*k.
  - rdata_ext is valid one cycle after ren_ext. rd_sum accumulates imem_rdata on cycles 1..imem_len.
  - Total duration is imem_len+1 cycles. On the final cycle, compare rd_sum (including that cycle's word) with wr_sum: equal -> RUN, else -> ERROR.
- RUN: cpu_enable=1, done=1. Stays until abort. start is ignored.
- ERROR: err=1, cpu_enable=0. Stays until abort.
- abort, any state: IDLE next cycle. A write presented in the abort cycle still completes. cpu_enable is low from the next cycle. Memory contents are not scrubbed. abort has priority over start and over stream acceptance for state/counter updates.
- start outside IDLE: ignored.
- Handshake: s_data is consumed only when s_valid&s_ready. s_ready never depends on s_valid.
- imem_wen and dmem_wen are never high together. imem_ren is never high with imem_wen.
- Async reset mid-load: immediate IDLE, outputs 0. Partial memory contents remain.

Decomposition:
- Package loader_pkg holds:
  - state enum (IDLE, LOAD_I, LOAD_D, VERIFY, RUN, ERROR)
  - IMEM_MAX_WORDS=512, DMEM_MAX_WORDS=1024
  - word-to-byte shift constant (2)
- Sub-module loader_csum: 32-bit clearable accumulator (clk, arst_n, clr, add_en, din, sum). Instantiated twice, for wr_sum and rd_sum.

Test Plan:
1. Basic load: imem_len=3, dmem_len=2, s_valid held high, words 0x11,0x22,0x33,0xA0,0xB0; start at cycle 0.
   - imem writes at addr 0,4,8; dmem writes at addr 0,4.
   - VERIFY cycles 6-9; cpu_enable first high at cycle 10.
   - cpu then fetches 0x11 at PC 0.
2. Backpressure: same as 1 with s_valid low every other cycle.
   - Identical memory contents.
   - No writes in gap cycles; RUN reached 5 cycles later than scenario 1.
3. Corruption: memory model flips bit 0 of imem word 1 on readback.
   - err=1 after VERIFY; cpu_enable stays 0.
   - abort -> IDLE, err=0.
4. Abort mid-load: abort during 2nd LOAD_D word.
   - IDLE next cycle; s_ready=0, busy=0.
   - A new start reloads correctly and reaches RUN.
5. Range and empty: start with imem_len=513 -> err=1, zero writes issued. start with imem_len=0, dmem_len=0 -> done=1 and cpu_enable=1 one cycle later, no memory traffic.
6. Reset mid-VERIFY: arst_n pulsed low -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader.
// Contents:
//   state_e         loader FSM states
//   IMEM_MAX_WORDS  largest legal instruction image, in words
//   DMEM_MAX_WORDS  largest legal data image, in words
//   ADDR_SHIFT      word index to byte address shift
//   word_to_byte    word index -> 32-bit byte address, upper bits zero
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_I = 3'd1,
    LOAD_D = 3'd2,
    VERIFY = 3'd3,
    RUN    = 3'd4,
    ERROR  = 3'd5
  } state_e;

  localparam int IMEM_MAX_WORDS = 512;
  localparam int DMEM_MAX_WORDS = 1024;
  localparam int ADDR_SHIFT     = 2;

  function automatic logic [31:0] word_to_byte(input logic [10:0] idx);
    logic [31:0] wide;
    wide = 32'(idx);
    return wide << ADDR_SHIFT;
  endfunction

endpackage

// File: rtl/loader_csum.sv
// Clearable modulo-2^W accumulator used for the write-side and read-side
// checksums of the loader.
// Ports:
//   clk     clock
//   arst_n  asynchronous active-low reset, clears the sum
//   clr     synchronous clear, takes priority over add_en
//   add_en  add din into the sum this cycle
//   din     value to accumulate
//   sum     current accumulated value
module loader_csum #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         clr,
  input  logic         add_en,
  input  logic [W-1:0] din,
  output logic [W-1:0] sum
);

  logic [W-1:0] sum_q;
  logic [W-1:0] sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (add_en) begin
      sum_d = sum_q + din;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader placed in front of the cpu. It takes a word stream
// on a valid/ready interface, writes the first imem_len words to instruction
// memory and the next dmem_len words to data memory through the cpu external
// memory ports, reads instruction memory back to compare checksums, and on a
// match enables the cpu.
// Ports:
//   clk, arst_n              clock and asynchronous active-low reset
//   start, abort             load request (IDLE only) / return to IDLE
//   imem_len, dmem_len       image sizes in words, latched at start
//   s_valid, s_data, s_ready input word stream
//   imem_addr/wen/ren/wdata  cpu addr_ext/wen_ext/ren_ext/wdata_ext
//   imem_rdata               cpu rdata_ext, valid one cycle after ren
//   dmem_addr/wen/wdata      cpu addr_ext_2/wen_ext_2/wdata_ext_2
//   cpu_enable               cpu enable, high only in RUN
//   busy, done, err          status: loading/verifying, running, failed
module program_loader
  import loader_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int IMEM_WORDS = IMEM_MAX_WORDS,
  parameter int DMEM_WORDS = DMEM_MAX_WORDS
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [9:0]        imem_len,
  input  logic [10:0]       dmem_len,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [31:0]       imem_addr,
  output logic              imem_wen,
  output logic              imem_ren,
  output logic [DATA_W-1:0] imem_wdata,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [31:0]       dmem_addr,
  output logic              dmem_wen,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              cpu_enable,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [10:0] IMEM_LIMIT = 11'(IMEM_WORDS);
  localparam logic [10:0] DMEM_LIMIT = 11'(DMEM_WORDS);

  state_e      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [9:0]  ilen_q, ilen_d;
  logic [10:0] dlen_q, dlen_d;

  logic [DATA_W-1:0] wr_sum;
  logic [DATA_W-1:0] rd_sum;
  logic [DATA_W-1:0] rd_total;
  logic              csum_clr;
  logic              wr_add;
  logic              rd_add;

  logic        accept;
  logic        len_ok;
  logic [10:0] ilen_ext;
  logic        last_i;
  logic        last_d;
  logic        verify_last;

  assign accept   = s_valid & s_ready;
  assign len_ok   = ({1'b0, imem_len} <= IMEM_LIMIT) && (dmem_len <= DMEM_LIMIT);
  assign ilen_ext = {1'b0, ilen_q};
  assign last_i   = (cnt_q == ilen_ext - 11'd1);
  assign last_d   = (cnt_q == dlen_q - 11'd1);
  // VERIFY runs imem_len+1 cycles: the extra cycle collects the final
  // readback word, whose data arrives one cycle after its read strobe.
  assign verify_last = (cnt_q == ilen_ext);
  // The final comparison must include the word arriving this cycle.
  assign rd_total = rd_sum + imem_rdata;

  // Only instruction words are checksummed; data words are not read back.
  assign wr_add = (state_q == LOAD_I) && accept && !abort;
  // Cycle 0 of VERIFY only issues the first read, no data is back yet.
  assign rd_add = (state_q == VERIFY) && (cnt_q != 11'd0) && !abort;

  loader_csum #(.W(DATA_W)) u_wr_csum (
    .clk    (clk),
    .arst_n (arst_n),
    .clr    (csum_clr),
    .add_en (wr_add),
    .din    (s_data),
    .sum    (wr_sum)
  );

  loader_csum #(.W(DATA_W)) u_rd_csum (
    .clk    (clk),
    .arst_n (arst_n),
    .clr    (csum_clr),
    .add_en (rd_add),
    .din    (imem_rdata),
    .sum    (rd_sum)
  );

  // State and counter registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ilen_q  <= '0;
      dlen_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ilen_q  <= ilen_d;
      dlen_q  <= dlen_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ilen_d   = ilen_q;
    dlen_d   = dlen_q;
    csum_clr = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (!len_ok) begin
            state_d = ERROR;
          end else begin
            ilen_d   = imem_len;
            dlen_d   = dmem_len;
            cnt_d    = '0;
            csum_clr = 1'b1;
            if (imem_len != 10'd0) begin
              state_d = LOAD_I;
            end else if (dmem_len != 11'd0) begin
              state_d = LOAD_D;
            end else begin
              state_d = RUN;
            end
          end
        end
      end
      LOAD_I: begin
        if (accept) begin
          if (last_i) begin
            cnt_d   = '0;
            state_d = (dlen_q != 11'd0) ? LOAD_D : VERIFY;
          end else begin
            cnt_d = cnt_q + 11'd1;
          end
        end
      end
      LOAD_D: begin
        if (accept) begin
          if (last_d) begin
            cnt_d   = '0;
            state_d = (ilen_q != 10'd0) ? VERIFY : RUN;
          end else begin
            cnt_d = cnt_q + 11'd1;
          end
        end
      end
      VERIFY: begin
        if (verify_last) begin
          cnt_d   = '0;
          state_d = (rd_total == wr_sum) ? RUN : ERROR;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      RUN:     state_d = RUN;
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase

    // abort wins over start and over stream acceptance; a write already on
    // the memory ports this cycle still lands because those are driven from
    // the current state alone.
    if (abort) begin
      state_d  = IDLE;
      cnt_d    = '0;
      csum_clr = 1'b0;
    end
  end

  // Outputs, combinational from state, counter and s_valid.
  always_comb begin
    s_ready    = 1'b0;
    imem_addr  = '0;
    imem_wen   = 1'b0;
    imem_ren   = 1'b0;
    imem_wdata = '0;
    dmem_addr  = '0;
    dmem_wen   = 1'b0;
    dmem_wdata = '0;
    cpu_enable = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;

    unique case (state_q)
      LOAD_I: begin
        s_ready    = 1'b1;
        busy       = 1'b1;
        imem_wen   = s_valid;
        imem_addr  = word_to_byte(cnt_q);
        imem_wdata = s_data;
      end
      LOAD_D: begin
        s_ready    = 1'b1;
        busy       = 1'b1;
        dmem_wen   = s_valid;
        dmem_addr  = word_to_byte(cnt_q);
        dmem_wdata = s_data;
      end
      VERIFY: begin
        busy = 1'b1;
        if (cnt_q < ilen_ext) begin
          imem_ren  = 1'b1;
          imem_addr = word_to_byte(cnt_q);
        end
      end
      RUN: begin
        cpu_enable = 1'b1;
        done       = 1'b1;
      end
      ERROR: begin
        err = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
